// File: rtl/vga_scanout_arbiter_pkg.sv
// Shared types for the VGA scanout arbiter: frame state encoding and pixel word width.
package vga_scanout_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_VSYNC = 2'd0,
        ST_ACTIVE     = 2'd1,
        ST_DONE       = 2'd2
    } frame_state_t;

    localparam int C_PIXEL_BITS = 24;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous show-ahead pixel FIFO with flush; pushes into a full FIFO and pops from
// an empty FIFO are ignored.
module vga_pixel_fifo
    import vga_scanout_arbiter_pkg::*;
#(
    parameter int C_depth = 16,
    parameter int C_width = C_PIXEL_BITS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [C_width-1:0]         push_data,
    input  logic                       pop,
    output logic [C_width-1:0]         pop_data,
    output logic [$clog2(C_depth):0]   count,
    output logic                       empty
);

    localparam int C_ptr_bits = $clog2(C_depth);
    localparam logic [C_ptr_bits:0] C_full = (C_ptr_bits + 1)'(C_depth);

    logic [C_width-1:0]    mem_r [C_depth];
    logic [C_ptr_bits-1:0] wr_ptr_r;
    logic [C_ptr_bits-1:0] rd_ptr_r;
    logic [C_ptr_bits:0]   count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Qualify push/pop against occupancy and expose the head entry.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != C_full) || do_pop_s);
        pop_data  = mem_r[rd_ptr_r];
        count     = count_r;
        empty     = (count_r == '0);
    end

    // Pointer and occupancy update; flush takes priority over any push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/vga_scanout_arbiter.sv
// Arbitrates a single-port framebuffer between display scanout prefetch and host writes,
// and drives registered pixels to vga2dvid from a small prefetch FIFO.
module vga_scanout_arbiter
    import vga_scanout_arbiter_pkg::*;
#(
    parameter int   C_resolution_x = 1280,
    parameter int   C_resolution_y = 720,
    parameter int   C_addr_bits    = 20,
    parameter int   C_fifo_depth   = 16,
    parameter int   C_low_water    = 4,
    parameter logic C_vsync_active = 1'b1
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    input  logic                    in_blank,
    input  logic                    in_vsync,
    output logic [C_addr_bits-1:0]  mem_addr,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [23:0]             mem_wdata,
    input  logic [23:0]             mem_rdata,
    input  logic                    host_valid,
    input  logic [C_addr_bits-1:0]  host_addr,
    input  logic [23:0]             host_wdata,
    output logic                    host_ready,
    output logic [7:0]              out_red,
    output logic [7:0]              out_green,
    output logic [7:0]              out_blue,
    output logic                    underrun
);

    localparam int C_count_bits = $clog2(C_fifo_depth) + 1;
    localparam int C_level_bits = C_count_bits + 1;
    localparam logic [C_addr_bits-1:0]  C_last_addr = C_addr_bits'(C_resolution_x * C_resolution_y - 1);
    localparam logic [C_level_bits-1:0] C_depth_lvl = C_level_bits'(C_fifo_depth);
    localparam logic [C_level_bits-1:0] C_low_lvl   = C_level_bits'(C_low_water);

    frame_state_t              state_r;
    frame_state_t              state_next_s;
    logic                      vsync_prev_r;
    logic                      vsync_edge_s;
    logic [C_addr_bits-1:0]    fetch_addr_r;
    logic                      rd_pending_r;
    logic [C_count_bits-1:0]   fifo_count_s;
    logic                      fifo_empty_s;
    logic [C_PIXEL_BITS-1:0]   fifo_data_s;
    logic [C_level_bits-1:0]   level_s;
    logic                      need_s;
    logic                      urgent_s;
    logic                      read_issue_s;
    logic                      host_grant_s;
    logic                      push_s;

    // Read data returning on the vsync edge belongs to the old frame and is dropped.
    assign vsync_edge_s = (in_vsync == C_vsync_active) && (vsync_prev_r != C_vsync_active);
    assign level_s      = C_level_bits'(fifo_count_s) + C_level_bits'(rd_pending_r);
    assign push_s       = rd_pending_r && !vsync_edge_s;

    vga_pixel_fifo #(
        .C_depth (C_fifo_depth),
        .C_width (C_PIXEL_BITS)
    ) u_fifo (
        .clk       (clk_pixel),
        .reset     (reset),
        .flush     (vsync_edge_s),
        .push      (push_s),
        .push_data (mem_rdata),
        .pop       (!in_blank),
        .pop_data  (fifo_data_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    // Frame state register and vsync history.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_r      <= ST_WAIT_VSYNC;
            vsync_prev_r <= ~C_vsync_active;
        end else begin
            state_r      <= state_next_s;
            vsync_prev_r <= in_vsync;
        end
    end

    // Frame state transitions: any vsync edge restarts the frame.
    always_comb begin
        state_next_s = state_r;
        if (vsync_edge_s) begin
            state_next_s = ST_ACTIVE;
        end else begin
            case (state_r)
                ST_WAIT_VSYNC: state_next_s = ST_WAIT_VSYNC;
                ST_ACTIVE: begin
                    if (read_issue_s && (fetch_addr_r == C_last_addr)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ACTIVE;
                    end
                end
                ST_DONE:       state_next_s = ST_DONE;
                default:       state_next_s = ST_WAIT_VSYNC;
            endcase
        end
    end

    // Per-cycle arbitration: urgent scanout, then host, then opportunistic scanout.
    always_comb begin
        need_s       = 1'b0;
        urgent_s     = 1'b0;
        read_issue_s = 1'b0;
        host_grant_s = 1'b0;
        if (!reset && !vsync_edge_s && (state_r == ST_ACTIVE)) begin
            need_s   = (level_s < C_depth_lvl);
            urgent_s = need_s && (level_s < C_low_lvl);
        end else begin
            need_s   = 1'b0;
            urgent_s = 1'b0;
        end
        if (reset) begin
            read_issue_s = 1'b0;
        end else if (urgent_s) begin
            read_issue_s = 1'b1;
        end else if (host_valid) begin
            host_grant_s = 1'b1;
        end else if (need_s) begin
            read_issue_s = 1'b1;
        end else begin
            read_issue_s = 1'b0;
            host_grant_s = 1'b0;
        end
    end

    // Memory port drive from the arbitration decision.
    always_comb begin
        mem_en     = read_issue_s || host_grant_s;
        mem_we     = host_grant_s;
        host_ready = host_grant_s;
        if (host_grant_s) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (read_issue_s) begin
            mem_addr  = fetch_addr_r;
            mem_wdata = 24'd0;
        end else begin
            mem_addr  = '0;
            mem_wdata = 24'd0;
        end
    end

    // Fetch address and outstanding-read tracking.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            fetch_addr_r <= '0;
            rd_pending_r <= 1'b0;
        end else begin
            rd_pending_r <= read_issue_s;
            if (vsync_edge_s) begin
                fetch_addr_r <= '0;
            end else if (read_issue_s) begin
                fetch_addr_r <= fetch_addr_r + 1'b1;
            end
        end
    end

    // Registered pixel output; an active pixel with nothing buffered latches underrun.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            out_red   <= 8'd0;
            out_green <= 8'd0;
            out_blue  <= 8'd0;
            underrun  <= 1'b0;
        end else if (!in_blank) begin
            if (fifo_empty_s) begin
                out_red   <= 8'd0;
                out_green <= 8'd0;
                out_blue  <= 8'd0;
                underrun  <= 1'b1;
            end else begin
                {out_red, out_green, out_blue} <= fifo_data_s;
            end
        end else begin
            out_red   <= 8'd0;
            out_green <= 8'd0;
            out_blue  <= 8'd0;
        end
    end

endmodule

// File: tb/tb_vga_scanout_arbiter.sv
// Directed testbench for vga_scanout_arbiter with a pattern-preloaded framebuffer model.
module tb_vga_scanout_arbiter;

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        in_blank;
    logic        in_vsync;
    logic [19:0] mem_addr;
    logic        mem_en;
    logic        mem_we;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata = 24'd0;
    logic        host_valid;
    logic [19:0] host_addr;
    logic [23:0] host_wdata;
    logic        host_ready;
    logic [7:0]  out_red;
    logic [7:0]  out_green;
    logic [7:0]  out_blue;
    logic        underrun;

    int total = 0;
    int bad   = 0;

    vga_scanout_arbiter dut (
        .clk_pixel  (clk_pixel),
        .reset      (reset),
        .in_blank   (in_blank),
        .in_vsync   (in_vsync),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .host_valid (host_valid),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ready (host_ready),
        .out_red    (out_red),
        .out_green  (out_green),
        .out_blue   (out_blue),
        .underrun   (underrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    function automatic logic [23:0] pattern(input logic [19:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return {lo, ~lo, 8'h55};
    endfunction

    // Framebuffer model: reads return the preload pattern one cycle later.
    always @(posedge clk_pixel) begin
        if (mem_en && !mem_we) mem_rdata <= pattern(mem_addr);
    end

    task automatic next_cycle();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_blank = 1'b1; in_vsync = 1'b0;
        host_valid = 1'b0; host_addr = 20'd0; host_wdata = 24'd0;
        repeat (3) next_cycle();
        reset = 1'b0;
        @(negedge clk_pixel);
        total++;
        if ({out_red, out_green, out_blue, underrun, mem_en, mem_we, host_ready, mem_addr, mem_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rgb=%h und=%b en=%b we=%b rdy=%b addr=%h wd=%h, expected all 0",
                     {out_red, out_green, out_blue}, underrun, mem_en, mem_we, host_ready, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_host_only();
        host_valid = 1'b1; host_addr = 20'hF1234; host_wdata = 24'hA5C3E7;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            @(negedge clk_pixel);
            total++;
            if (host_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
                mem_addr !== 20'hF1234 || mem_wdata !== 24'hA5C3E7) begin
                bad++;
                $display("FAIL host_only[%0d]: got rdy=%b en=%b we=%b addr=%h wd=%h, expected 1 1 1 f1234 a5c3e7",
                         i, host_ready, mem_en, mem_we, mem_addr, mem_wdata);
            end
        end
    endtask

    task automatic test_vsync_fill();
        next_cycle();
        in_vsync = 1'b1;
        @(negedge clk_pixel);
        total++;
        if (host_ready !== 1'b1 || mem_we !== 1'b1) begin
            bad++;
            $display("FAIL edge_cycle_host: got rdy=%b we=%b, expected 1 1", host_ready, mem_we);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk_pixel);
            total++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || host_ready !== 1'b0 || mem_addr !== 20'(i)) begin
                bad++;
                $display("FAIL urgent_read[%0d]: got en=%b we=%b rdy=%b addr=%h, expected 1 0 0 %h",
                         i, mem_en, mem_we, host_ready, mem_addr, 20'(i));
            end
        end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (i == 2) in_vsync = 1'b0;
            @(negedge clk_pixel);
            total++;
            if (host_ready !== 1'b1 || mem_we !== 1'b1) begin
                bad++;
                $display("FAIL host_at_low_water[%0d]: got rdy=%b we=%b, expected 1 1", i, host_ready, mem_we);
            end
        end
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            host_valid = 1'b0;
            @(negedge clk_pixel);
            total++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 20'(i + 4)) begin
                bad++;
                $display("FAIL fill_read[%0d]: got en=%b we=%b addr=%h, expected 1 0 %h",
                         i, mem_en, mem_we, mem_addr, 20'(i + 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk_pixel);
            total++;
            if (mem_en !== 1'b0) begin
                bad++;
                $display("FAIL fifo_full_idle[%0d]: got en=%b, expected 0", i, mem_en);
            end
        end
    endtask

    task automatic test_active_line();
        int exp_fetch;
        logic ok;
        exp_fetch = 16;
        host_valid = 1'b1;
        for (int i = 0; i <= 1280; i++) begin
            next_cycle();
            in_blank = (i < 1280) ? 1'b0 : 1'b1;
            @(negedge clk_pixel);
            if (i > 0) begin
                total++;
                if ({out_red, out_green, out_blue} !== pattern(20'(i - 1)) || underrun !== 1'b0) begin
                    bad++;
                    $display("FAIL line_pixel[%0d]: got rgb=%h und=%b, expected %h 0",
                             i - 1, {out_red, out_green, out_blue}, underrun, pattern(20'(i - 1)));
                end
            end
            if (host_ready) ok = (mem_en === 1'b1) && (mem_we === 1'b1) && (mem_addr === 20'hF1234);
            else            ok = (mem_en === 1'b1) && (mem_we === 1'b0) && (mem_addr === 20'(exp_fetch));
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL line_arb[%0d]: got rdy=%b en=%b we=%b addr=%h, expected host grant or read at %h",
                         i, host_ready, mem_en, mem_we, mem_addr, 20'(exp_fetch));
            end
            if (mem_en && !mem_we) exp_fetch++;
        end
        next_cycle();
        @(negedge clk_pixel);
        total++;
        if ({out_red, out_green, out_blue} !== 24'd0) begin
            bad++;
            $display("FAIL blank_black: got rgb=%h, expected 000000", {out_red, out_green, out_blue});
        end
    endtask

    task automatic test_vsync_inflight();
        next_cycle();
        host_valid = 1'b0;
        @(negedge clk_pixel);
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL pre_edge_read: got en=%b we=%b, expected 1 0", mem_en, mem_we);
        end
        next_cycle();
        in_vsync = 1'b1;
        @(negedge clk_pixel);
        total++;
        if (mem_en !== 1'b0) begin
            bad++;
            $display("FAIL edge_no_read: got en=%b, expected 0", mem_en);
        end
        next_cycle();
        @(negedge clk_pixel);
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 20'd0) begin
            bad++;
            $display("FAIL restart_addr: got en=%b we=%b addr=%h, expected 1 0 00000", mem_en, mem_we, mem_addr);
        end
        repeat (20) next_cycle();
        in_blank = 1'b0;
        next_cycle();
        @(negedge clk_pixel);
        total++;
        if ({out_red, out_green, out_blue} !== pattern(20'd0)) begin
            bad++;
            $display("FAIL first_pixel: got %h, expected %h", {out_red, out_green, out_blue}, pattern(20'd0));
        end
        next_cycle();
        in_blank = 1'b1;
        @(negedge clk_pixel);
        total++;
        if ({out_red, out_green, out_blue} !== pattern(20'd1)) begin
            bad++;
            $display("FAIL second_pixel: got %h, expected %h", {out_red, out_green, out_blue}, pattern(20'd1));
        end
        in_vsync = 1'b0;
    endtask

    task automatic test_underrun();
        next_cycle();
        reset = 1'b1; in_vsync = 1'b0; in_blank = 1'b1; host_valid = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        @(negedge clk_pixel);
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL underrun_after_reset: got %b, expected 0", underrun);
        end
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            in_blank = 1'b0;
            @(negedge clk_pixel);
            total++;
            if ({out_red, out_green, out_blue} !== 24'd0 || (i > 0 && underrun !== 1'b1)) begin
                bad++;
                $display("FAIL starved_pixel[%0d]: got rgb=%h und=%b, expected 000000 %b",
                         i, {out_red, out_green, out_blue}, underrun, (i > 0));
            end
        end
        next_cycle();
        in_blank = 1'b1;
        in_vsync = 1'b1;
        repeat (5) next_cycle();
        @(negedge clk_pixel);
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL underrun_sticky: got %b, expected 1", underrun);
        end
        next_cycle();
        reset = 1'b1;
        in_vsync = 1'b0;
        next_cycle();
        reset = 1'b0;
        @(negedge clk_pixel);
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL underrun_cleared: got %b, expected 0", underrun);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host_only();
        test_vsync_fill();
        test_active_line();
        test_vsync_inflight();
        test_underrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
